// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the two-port data-memory arbiter:
//   - sequencer state encoding (IDLE -> ACCESS -> RESP)
//   - RISC-V load/store funct3 codes understood by data_mem
//   - requester port identifiers
//   - round-robin winner selection helper
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

    // Sequencer states, kept as plain constants for legacy tool flows.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // funct3 access-size codes.
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Requester identifiers (index into the per-port vectors).
    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

    // Round-robin pick: a lone requester wins outright; on a tie the port
    // that was not granted last time wins. Only meaningful when req != 0.
    function automatic logic rr_pick(input logic [1:0] req, input logic last_gnt);
        logic winner;
        if (req == 2'b11) begin
            winner = ~last_gnt;
        end else begin
            winner = req[1];
        end
        return winner;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// ---------------------------------------------------------------------------
// dmem_arbiter_if
// Requester-side bus of the data-memory arbiter. Both ports share one
// bundle; port i occupies bit i / slice i of every vector.
//   req    [1:0]            request, held until ack
//   we     [1:0]            1 = store, 0 = load
//   funct3 [5:0]            port i at [3i+2:3i]
//   addr   [2*ADDR_WIDTH]   byte address, port i at slice i
//   wdata  [2*DATA_WIDTH]   right-aligned store data, port i at slice i
//   ack    [1:0]            pulse: request accepted, inputs captured
//   done   [1:0]            pulse: access completed
//   err                     valid with done, 1 = access rejected
//   rdata  [DATA_WIDTH]     load result, valid with done
// master = requesters, slave = arbiter.
// ---------------------------------------------------------------------------
interface dmem_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic [1:0]              req;
    logic [1:0]              we;
    logic [5:0]              funct3;
    logic [2*ADDR_WIDTH-1:0] addr;
    logic [2*DATA_WIDTH-1:0] wdata;
    logic [1:0]              ack;
    logic [1:0]              done;
    logic                    err;
    logic [DATA_WIDTH-1:0]   rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  ack, done, err, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output ack, done, err, rdata
    );
endinterface

// File: rtl/dmem_align_check.sv
// ---------------------------------------------------------------------------
// dmem_align_check
// Combinational legality check for a single data-memory access. Rejects
// funct3 codes data_mem does not implement for the given direction and
// halfword/word accesses that are not naturally aligned.
//   we_i       1 = store, 0 = load
//   funct3_i   RISC-V funct3 of the access
//   addr_i     low two bits of the byte address
//   legal_o    1 = access may be issued to memory
// ---------------------------------------------------------------------------
module dmem_align_check
    import dmem_arb_pkg::*;
(
    input  logic       we_i,
    input  logic [2:0] funct3_i,
    input  logic [1:0] addr_i,
    output logic       legal_o
);

    // Legality decode; unsigned variants exist for loads only.
    always_comb begin
        legal_o = 1'b0;
        case (funct3_i)
            F3_B:    legal_o = 1'b1;
            F3_H:    legal_o = ~addr_i[0];
            F3_W:    legal_o = (addr_i == 2'b00);
            F3_BU:   legal_o = ~we_i;
            F3_HU:   legal_o = ~we_i & ~addr_i[0];
            default: legal_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Two-port round-robin arbiter and sequencer in front of data_mem.
// Port 0 is the core LSU, port 1 the debug/program-loader port. One access
// is in flight at a time: IDLE (grant + capture) -> ACCESS (drive memory)
// -> RESP (done/err pulse), i.e. one access every three cycles.
// Misaligned or unsupported accesses never reach memory; they complete
// with err=1 (loads return 0, stores leave memory untouched).
//
// Ports
//   clk_i          system clock, all state on posedge
//   reset_i        synchronous active-high reset
//   arb_if         requester bus (slave side), see dmem_arbiter_if
//   mem_wr_en_o    data_mem write enable
//   mem_funct3_o   data_mem access size
//   mem_addr_o     data_mem byte address
//   mem_wr_data_o  data_mem write data
//   mem_rd_data_i  data_mem combinational read data
// ---------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    dmem_arbiter_if.slave         arb_if,
    output logic                  mem_wr_en_o,
    output logic [2:0]            mem_funct3_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [DATA_WIDTH-1:0] mem_wr_data_o,
    input  logic [DATA_WIDTH-1:0] mem_rd_data_i
);

    logic [1:0]            state_q;
    logic [1:0]            state_d;
    logic                  last_gnt_q;

    // Captured request, held stable for the whole access.
    logic                  cap_we_q;
    logic [2:0]            cap_funct3_q;
    logic [ADDR_WIDTH-1:0] cap_addr_q;
    logic [DATA_WIDTH-1:0] cap_wdata_q;
    logic                  cap_port_q;

    logic [DATA_WIDTH-1:0] rdata_q;
    logic [1:0]            done_q;
    logic                  err_q;

    logic                  gnt_valid_s;
    logic                  gnt_port_s;
    logic [1:0]            ack_s;
    logic                  legal_s;
    logic                  in_access_s;

    // Legality is judged on the captured request so it stays constant
    // through ACCESS and RESP.
    dmem_align_check u_align_check (
        .we_i     (cap_we_q),
        .funct3_i (cap_funct3_q),
        .addr_i   (cap_addr_q[1:0]),
        .legal_o  (legal_s)
    );

    // Grant decision; ack is combinational in the grant cycle and is
    // suppressed under reset because nothing gets captured then.
    always_comb begin
        gnt_valid_s = 1'b0;
        gnt_port_s  = PORT_CORE;
        ack_s       = 2'b00;
        if ((state_q == ST_IDLE) && (arb_if.req != 2'b00) && !reset_i) begin
            gnt_valid_s = 1'b1;
            gnt_port_s  = rr_pick(arb_if.req, last_gnt_q);
            ack_s       = (gnt_port_s == PORT_DBG) ? 2'b10 : 2'b01;
        end else begin
            gnt_valid_s = 1'b0;
            gnt_port_s  = PORT_CORE;
            ack_s       = 2'b00;
        end
    end

    // Sequencer next-state logic.
    always_comb begin
        state_d = ST_IDLE;
        case (state_q)
            ST_IDLE: begin
                if (gnt_valid_s) begin
                    state_d = ST_ACCESS;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Sequencer state, request capture, and response registers.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            last_gnt_q   <= 1'b1;
            cap_we_q     <= 1'b0;
            cap_funct3_q <= 3'b000;
            cap_addr_q   <= '0;
            cap_wdata_q  <= '0;
            cap_port_q   <= 1'b0;
            rdata_q      <= '0;
            done_q       <= 2'b00;
            err_q        <= 1'b0;
        end else begin
            state_q <= state_d;

            if (gnt_valid_s) begin
                last_gnt_q   <= gnt_port_s;
                cap_port_q   <= gnt_port_s;
                cap_we_q     <= arb_if.we[gnt_port_s];
                cap_funct3_q <= arb_if.funct3[3*gnt_port_s +: 3];
                cap_addr_q   <= arb_if.addr[ADDR_WIDTH*gnt_port_s +: ADDR_WIDTH];
                cap_wdata_q  <= arb_if.wdata[DATA_WIDTH*gnt_port_s +: DATA_WIDTH];
            end

            // done/err are registered at the end of ACCESS so they are high
            // exactly during the RESP cycle.
            if (state_q == ST_ACCESS) begin
                done_q <= (cap_port_q == PORT_DBG) ? 2'b10 : 2'b01;
                err_q  <= ~legal_s;
                // Stores leave rdata untouched; illegal loads return zero.
                if (!cap_we_q) begin
                    rdata_q <= legal_s ? mem_rd_data_i : '0;
                end
            end else begin
                done_q <= 2'b00;
                err_q  <= 1'b0;
            end
        end
    end

    assign in_access_s = (state_q == ST_ACCESS);

    // Write strobe is gated by reset so a reset in ACCESS commits nothing.
    assign mem_wr_en_o   = in_access_s & cap_we_q & legal_s & ~reset_i;
    assign mem_funct3_o  = cap_funct3_q;
    assign mem_addr_o    = cap_addr_q;
    assign mem_wr_data_o = cap_wdata_q;

    assign arb_if.ack   = ack_s;
    assign arb_if.done  = done_q;
    assign arb_if.err   = err_q;
    assign arb_if.rdata = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed self-checking bench for dmem_arbiter with a byte-addressable
// behavioural data_mem attached to the memory side.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;
    import dmem_arb_pkg::*;

    localparam int DW = 32;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_clr;
    logic          mem_wr_en;
    logic [2:0]    mem_funct3;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wr_data;
    logic [DW-1:0] mem_rd_data;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    dmem_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .arb_if        (bus),
        .mem_wr_en_o   (mem_wr_en),
        .mem_funct3_o  (mem_funct3),
        .mem_addr_o    (mem_addr),
        .mem_wr_data_o (mem_wr_data),
        .mem_rd_data_i (mem_rd_data)
    );

    // Behavioural data_mem: 256 bytes, little-endian, combinational read.
    logic [7:0] mem [0:255];
    logic [7:0] ma0, ma1, ma2, ma3;

    always_comb begin
        ma0 = mem_addr[7:0];
        ma1 = ma0 + 8'd1;
        ma2 = ma0 + 8'd2;
        ma3 = ma0 + 8'd3;
        case (mem_funct3)
            3'b000:  mem_rd_data = {{24{mem[ma0][7]}}, mem[ma0]};
            3'b001:  mem_rd_data = {{16{mem[ma1][7]}}, mem[ma1], mem[ma0]};
            3'b010:  mem_rd_data = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
            3'b100:  mem_rd_data = {24'd0, mem[ma0]};
            3'b101:  mem_rd_data = {16'd0, mem[ma1], mem[ma0]};
            default: mem_rd_data = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
        end else if (mem_wr_en) begin
            case (mem_funct3)
                3'b000: mem[ma0] <= mem_wr_data[7:0];
                3'b001: begin
                    mem[ma0] <= mem_wr_data[7:0];
                    mem[ma1] <= mem_wr_data[15:8];
                end
                3'b010: begin
                    mem[ma0] <= mem_wr_data[7:0];
                    mem[ma1] <= mem_wr_data[15:8];
                    mem[ma2] <= mem_wr_data[23:16];
                    mem[ma3] <= mem_wr_data[31:24];
                end
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_port(input int p, input logic w, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] wd);
        bus.req[p]         = 1'b1;
        bus.we[p]          = w;
        bus.funct3[3*p+:3] = f3;
        bus.addr[32*p+:32] = a;
        bus.wdata[32*p+:32] = wd;
    endtask

    // One complete transaction on port p with its expected outcome.
    task automatic xfer(input string tag, input int p, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_wen, input logic exp_err, input logic [31:0] exp_rd);
        logic got;
        logic [1:0] exp_vec;
        exp_vec = (p == 1) ? 2'b10 : 2'b01;
        @(posedge clk); #1;
        drive_port(p, w, f3, a, wd);
        got = 1'b0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk);
            if (bus.ack[p]) got = 1'b1;
        end
        check({tag, " ack_seen"}, {31'd0, got}, 32'd1);
        check({tag, " ack_vec"}, {30'd0, bus.ack}, {30'd0, exp_vec});
        @(posedge clk); #1;
        bus.req[p] = 1'b0;
        @(negedge clk);
        check({tag, " wr_en"}, {31'd0, mem_wr_en}, {31'd0, exp_wen});
        check({tag, " mem_addr"}, mem_addr, a);
        check({tag, " done_in_access"}, {30'd0, bus.done}, 32'd0);
        @(negedge clk);
        check({tag, " done"}, {30'd0, bus.done}, {30'd0, exp_vec});
        check({tag, " err"}, {31'd0, bus.err}, {31'd0, exp_err});
        check({tag, " rdata"}, bus.rdata, exp_rd);
    endtask

    int   rr_port [0:3];
    int   rr_cyc  [0:3];
    int   rr_k;
    logic got_ack;

    initial begin
        reset = 1'b1;
        mem_clr = 1'b1;
        bus.req = 2'b00; bus.we = 2'b00; bus.funct3 = 6'd0;
        bus.addr = '0; bus.wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset ack", {30'd0, bus.ack}, 32'd0);
        check("reset done", {30'd0, bus.done}, 32'd0);
        check("reset err", {31'd0, bus.err}, 32'd0);
        check("reset rdata", bus.rdata, 32'd0);
        check("reset wr_en", {31'd0, mem_wr_en}, 32'd0);
        check("reset mem_addr", mem_addr, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        mem_clr = 1'b0;

        // Both ports request continuously straight out of reset.
        drive_port(0, 1'b0, F3_W, 32'h10, 32'd0);
        drive_port(1, 1'b0, F3_W, 32'h20, 32'd0);
        rr_k = 0;
        for (int n = 0; n < 40 && rr_k < 4; n++) begin
            @(negedge clk);
            check("rr ack_done_excl", {31'd0, (bus.ack != 2'b00) && (bus.done != 2'b00)}, 32'd0);
            if (bus.ack != 2'b00) begin
                check("rr ack_onehot", $countones(bus.ack), 32'd1);
                rr_port[rr_k] = int'(bus.ack[1]);
                rr_cyc[rr_k]  = cyc;
                rr_k++;
            end
        end
        check("rr grant_count", rr_k, 32'd4);
        if (rr_k == 4) begin
            check("rr order0", rr_port[0], 32'd0);
            check("rr order1", rr_port[1], 32'd1);
            check("rr order2", rr_port[2], 32'd0);
            check("rr order3", rr_port[3], 32'd1);
            check("rr gap01", rr_cyc[1] - rr_cyc[0], 32'd3);
            check("rr gap12", rr_cyc[2] - rr_cyc[1], 32'd3);
            check("rr gap23", rr_cyc[3] - rr_cyc[2], 32'd3);
        end
        @(posedge clk); #1;
        bus.req = 2'b00;
        repeat (3) @(negedge clk);

        // Store/load round trip across ports.
        xfer("sw_dead",   0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 1'b1, 1'b0, 32'h00000000);
        xfer("lw_dead",   1, 1'b0, F3_W,  32'h10, 32'd0,        1'b0, 1'b0, 32'hDEADBEEF);
        // Byte store and sign/zero-extended reloads.
        xfer("sb_80",     0, 1'b1, F3_B,  32'h13, 32'h00000080, 1'b1, 1'b0, 32'hDEADBEEF);
        xfer("lb_13",     0, 1'b0, F3_B,  32'h13, 32'd0,        1'b0, 1'b0, 32'hFFFFFF80);
        xfer("lbu_13",    1, 1'b0, F3_BU, 32'h13, 32'd0,        1'b0, 1'b0, 32'h00000080);
        xfer("lw_10",     0, 1'b0, F3_W,  32'h10, 32'd0,        1'b0, 1'b0, 32'h80ADBEEF);
        // Misaligned halfword store is blocked.
        xfer("sw_cafe",   1, 1'b1, F3_W,  32'h20, 32'hCAFEF00D, 1'b1, 1'b0, 32'h80ADBEEF);
        xfer("sh_mis",    0, 1'b1, F3_H,  32'h21, 32'h00001234, 1'b0, 1'b1, 32'h80ADBEEF);
        xfer("lw_20",     0, 1'b0, F3_W,  32'h20, 32'd0,        1'b0, 1'b0, 32'hCAFEF00D);
        xfer("lh_22",     1, 1'b0, F3_H,  32'h22, 32'd0,        1'b0, 1'b0, 32'hFFFFCAFE);
        xfer("lhu_20",    0, 1'b0, F3_HU, 32'h20, 32'd0,        1'b0, 1'b0, 32'h0000F00D);
        xfer("lw_mis",    1, 1'b0, F3_W,  32'h22, 32'd0,        1'b0, 1'b1, 32'h00000000);
        xfer("lbu_20",    0, 1'b0, F3_BU, 32'h20, 32'd0,        1'b0, 1'b0, 32'h0000000D);
        // Unsupported funct3 codes.
        xfer("ld_f3_011", 0, 1'b0, 3'b011, 32'h0, 32'd0,        1'b0, 1'b1, 32'h00000000);
        xfer("st_f3_100", 1, 1'b1, 3'b100, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 32'h00000000);
        xfer("sb_odd",    1, 1'b1, F3_B,  32'h1, 32'h000000A5,  1'b1, 1'b0, 32'h00000000);
        xfer("lw_0",      0, 1'b0, F3_W,  32'h0, 32'd0,         1'b0, 1'b0, 32'h0000A500);

        // Reset during the ACCESS cycle of a store.
        xfer("sw_1122",   0, 1'b1, F3_W,  32'h30, 32'h11223344, 1'b1, 1'b0, 32'h0000A500);
        @(posedge clk); #1;
        drive_port(0, 1'b1, F3_W, 32'h30, 32'h00000055);
        got_ack = 1'b0;
        for (int n = 0; n < 10 && !got_ack; n++) begin
            @(negedge clk);
            if (bus.ack[0]) got_ack = 1'b1;
        end
        check("rst_mid ack_seen", {31'd0, got_ack}, 32'd1);
        @(posedge clk); #1;
        bus.req[0] = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid wr_en", {31'd0, mem_wr_en}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid no_done", {30'd0, bus.done}, 32'd0);
        check("rst_mid no_err", {31'd0, bus.err}, 32'd0);
        // Arbiter must already be in IDLE: a fresh request is acked at once.
        drive_port(1, 1'b0, F3_W, 32'h30, 32'd0);
        #1;
        check("rst_mid idle_ack", {30'd0, bus.ack}, 32'd2);
        @(posedge clk); #1;
        bus.req[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_mid lw_done", {30'd0, bus.done}, 32'd2);
        check("rst_mid lw_old", bus.rdata, 32'h11223344);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the byte-addressable data memory (data_mem).
- Port 0 is the core load/store unit; port 1 is the debug/program-loader port.
- Grants one access at a time using round-robin and drives the memory's wr_en/funct3/addr/wr_data.
- Blocks misaligned and illegal-funct3 accesses, which the memory would otherwise silently corrupt, and returns registered read data with a per-port done/err pulse.

Parameters:
- DATA_WIDTH, 32, data bus width.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-port request; bit i = port i.
- we  in  2  per-port write enable (1 = store, 0 = load).
- funct3  in  6  per-port RISC-V funct3; port i at [3i+2:3i].
- addr  in  2*ADDR_WIDTH  per-port byte address; port i at slice i.
- wdata  in  2*DATA_WIDTH  per-port store data, right-aligned (sb uses [7:0], sh uses [15:0]).
- ack  out  2  one-cycle pulse; the request was accepted and its inputs captured.
- done  out  2  one-cycle pulse; the access completed.
- err  out  1  valid with done; 1 = access rejected.
- rdata  out  DATA_WIDTH  load result, valid with done; holds value until the next capture.
- mem_wr_en  out  1  to data_mem wr_en.
- mem_funct3  out  3  to data_mem funct3.
- mem_addr  out  ADDR_WIDTH  to data_mem address.
- mem_wr_data  out  DATA_WIDTH  to data_mem write data.
- mem_rd_data  in  DATA_WIDTH  from data_mem; combinational read.

Behaviour:
- Reset values: state=IDLE, last_gnt=1 (so port 0 wins the first tie), ack=0, done=0, err=0, rdata=0, mem_wr_en=0, captured regs=0.
- FSM states: IDLE -> ACCESS -> RESP -> IDLE. Throughput is one access per 3 cycles.
- IDLE, no req: stay in IDLE.
- IDLE, one req: grant that port.
- IDLE, both req: grant the port != last_gnt.
- On grant: ack[w]=1 combinationally in that cycle; capture we, funct3, addr, wdata, port id; set last_gnt=w; go to ACCESS.
- ACCESS:
  - mem_funct3/mem_addr/mem_wr_data are driven from the captured regs.
  - mem_wr_en = cap_we & legal & ~reset.
  - For a legal load, capture mem_rd_data into rdata. For an illegal load, rdata=0.
  - Go to RESP.
- RESP: done[cap_port]=1, err=~legal; go to IDLE. No request is accepted in RESP.
- Legal rules:
  - Store funct3 must be 000, 001 or 010.
  - Load funct3 must be 000, 001, 010, 100 or 101.
  - Halfword (001/101): addr[0] must be 0.
  - Word (010): addr[1:0] must be 00.
  - Byte: any alignment.
- Outside ACCESS: mem_wr_en=0; mem_funct3/mem_addr/mem_wr_data hold the captured values.
- A requester holds req (and its inputs) until ack. Deasserting req before ack is legal and produces no transaction. req still high after ack is a new request at the next IDLE.
- ack and done are never asserted together, and never to both ports in the same cycle.
- Reset mid-operation: no write commits in the reset cycle (mem_wr_en gated). No done/err pulse. Next state is IDLE.
- A store error leaves memory unchanged. A store's rdata is unspecified-but-stable (rdata holds its previous value).

Decomposition:
- dmem_arb_pkg holds:
  - state encoding: IDLE, ACCESS, RESP.
  - funct3 constants: F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - port ids: PORT_CORE=0, PORT_DBG=1.
- One combinational sub-module, dmem_align_check (inputs we, funct3, addr[1:0]; output legal), shared with future cache/LSU logic.

Test Plan:
- Port0 sw 0xDEADBEEF @0x10 -> ack0 in cycle T, mem_wr_en=1 at T+1, done0 at T+2 with err=0; then port1 lw @0x10 -> done1, rdata=0xDEADBEEF.
- Both ports request continuously from reset -> grant order 0,1,0,1; ack pulses are 3 cycles apart; the first grant after reset goes to port 0.
- sb 0x80 @0x13, then lb @0x13 -> rdata=0xFFFFFF80; lbu @0x13 -> 0x00000080; lw @0x10 -> byte 3 = 0x80, other bytes unchanged.
- sh 0x1234 @0x21 (misaligned) -> err=1 with done, mem_wr_en never high; lw @0x20 then returns the prior contents.
- Load with funct3=011 @0x0 -> err=1, rdata=0; store with funct3=100 -> err=1, no write.
- reset asserted in the ACCESS cycle of sw 0x55 @0x30 -> mem_wr_en=0, no done, IDLE the next cycle; lw @0x30 shows the old value.
